// File: rtl/alu_arbiter.sv
// Round-robin front end that time-shares one combinational ALU among NREQ requesters.
// Each operation accepts a request, holds the operands on the ALU for one cycle, then returns the registered result.
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_IDLE | scan requesters from ptr, accept the first valid one
// ST_EXEC | operands on the ALU, result captured on the next edge
// ST_RESP | resp_valid to the granted requester until it takes the result
module alu_arbiter #(
  parameter int XLEN = 64,
  parameter int NREQ = 4,
  localparam int IW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*XLEN-1:0] req_a,
  input  logic [NREQ*XLEN-1:0] req_b,
  input  logic [NREQ*3-1:0]    req_ctrl,
  output logic [NREQ-1:0]      resp_valid,
  input  logic [NREQ-1:0]      resp_ready,
  output logic [XLEN-1:0]      resp_result,
  output logic                 resp_zero,
  output logic [XLEN-1:0]      alu_a,
  output logic [XLEN-1:0]      alu_b,
  output logic [2:0]           alu_ctrl,
  input  logic [XLEN-1:0]      alu_result,
  input  logic                 alu_zero,
  output logic                 busy
);

  localparam int IW1 = IW + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [IW-1:0]   gnt;
  logic [IW-1:0]   ptr;
  logic [IW-1:0]   scan_gnt;
  logic [IW1-1:0]  scan_idx;
  logic            scan_found;
  logic [NREQ-1:0] scan_oh;
  logic [NREQ-1:0] gnt_oh;
  logic            accept;
  logic            resp_done;

  logic [XLEN-1:0] a_arr    [NREQ];
  logic [XLEN-1:0] b_arr    [NREQ];
  logic [2:0]      ctrl_arr [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign a_arr[i]    = req_a[i*XLEN +: XLEN];
    assign b_arr[i]    = req_b[i*XLEN +: XLEN];
    assign ctrl_arr[i] = req_ctrl[i*3 +: 3];
  end

  // Scan ptr, ptr+1, ... with an explicit wrap so NREQ need not be a power of two.
  always_comb begin
    scan_found = 1'b0;
    scan_gnt   = '0;
    scan_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      scan_idx = {1'b0, ptr} + IW1'(k);
      if (scan_idx >= IW1'(NREQ)) begin
        scan_idx = scan_idx - IW1'(NREQ);
      end
      if (!scan_found && req_valid[scan_idx[IW-1:0]]) begin
        scan_found = 1'b1;
        scan_gnt   = scan_idx[IW-1:0];
      end
    end
  end

  always_comb begin
    scan_oh           = '0;
    scan_oh[scan_gnt] = 1'b1;
    gnt_oh            = '0;
    gnt_oh[gnt]       = 1'b1;
  end

  assign accept    = (state == ST_IDLE) && scan_found;
  assign resp_done = (state == ST_RESP) && resp_ready[gnt];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (scan_found) state_nxt = ST_EXEC;
      ST_EXEC: state_nxt = ST_RESP;
      ST_RESP: if (resp_ready[gnt]) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // req_ready is gated by rst_n so no requester sees an accept during reset.
  assign req_ready  = (accept && rst_n) ? scan_oh : '0;
  assign resp_valid = (state == ST_RESP) ? gnt_oh : '0;
  assign busy       = (state != ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt         <= '0;
      ptr         <= '0;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_ctrl    <= '0;
      resp_result <= '0;
      resp_zero   <= 1'b0;
    end else begin
      if (accept) begin
        alu_a    <= a_arr[scan_gnt];
        alu_b    <= b_arr[scan_gnt];
        alu_ctrl <= ctrl_arr[scan_gnt];
        gnt      <= scan_gnt;
      end
      if (state == ST_EXEC) begin
        resp_result <= alu_result;
        resp_zero   <= alu_zero;
      end
      if (resp_done) begin
        ptr <= (gnt == IW'(NREQ - 1)) ? '0 : gnt + IW'(1);
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: an adder stub stands in for the ALU, and a scoreboard checks
// each grant, its latency and its result against a simple round-robin reference model.
module tb_alu_arbiter;

  localparam int XLEN = 64;
  localparam int NREQ = 4;

  logic                 clk;
  logic                 rst_n;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*XLEN-1:0] req_a;
  logic [NREQ*XLEN-1:0] req_b;
  logic [NREQ*3-1:0]    req_ctrl;
  logic [NREQ-1:0]      resp_valid;
  logic [NREQ-1:0]      resp_ready;
  logic [XLEN-1:0]      resp_result;
  logic                 resp_zero;
  logic [XLEN-1:0]      alu_a;
  logic [XLEN-1:0]      alu_b;
  logic [2:0]           alu_ctrl;
  logic [XLEN-1:0]      alu_result;
  logic                 alu_zero;
  logic                 busy;

  logic [XLEN-1:0] ra [NREQ];
  logic [XLEN-1:0] rb [NREQ];
  logic [2:0]      rc [NREQ];

  int total = 0;
  int bad   = 0;

  alu_arbiter #(.XLEN(XLEN), .NREQ(NREQ)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_ctrl(req_ctrl),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_result(resp_result), .resp_zero(resp_zero),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .busy(busy)
  );

  assign alu_result = alu_a + alu_b;
  assign alu_zero   = (alu_result == '0);

  for (genvar i = 0; i < NREQ; i++) begin : g_pack
    assign req_a[i*XLEN +: XLEN] = ra[i];
    assign req_b[i*XLEN +: XLEN] = rb[i];
    assign req_ctrl[i*3 +: 3]    = rc[i];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one outstanding operation, round-robin pointer, result = a + b.
  typedef struct {
    int              g;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [2:0]      c;
    logic [XLEN-1:0] r;
    logic            z;
  } exp_t;

  exp_t q[$];
  int   glog[$];
  int   m_ptr  = 0;
  bit   m_busy = 0;
  int   m_age  = 0;
  exp_t e;
  exp_t h;
  bit   found;
  int   g;
  int   idx;

  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      m_busy = 0;
      m_ptr  = 0;
      chk("rst_req_ready", 64'(req_ready), 64'd0);
      chk("rst_resp_valid", 64'(resp_valid), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_resp_result", resp_result, 64'd0);
      chk("rst_resp_zero", 64'(resp_zero), 64'd0);
      chk("rst_alu_a", alu_a, 64'd0);
      chk("rst_alu_b", alu_b, 64'd0);
      chk("rst_alu_ctrl", 64'(alu_ctrl), 64'd0);
    end else if (!m_busy) begin
      found = 0;
      g     = 0;
      for (int k = 0; k < NREQ; k++) begin
        idx = (m_ptr + k) % NREQ;
        if (!found && req_valid[idx]) begin
          found = 1;
          g     = idx;
        end
      end
      chk("idle_busy", 64'(busy), 64'd0);
      chk("idle_resp_valid", 64'(resp_valid), 64'd0);
      if (found) begin
        chk("grant", 64'(req_ready), 64'd1 << g);
        e.g = g;
        e.a = ra[g];
        e.b = rb[g];
        e.c = rc[g];
        e.r = ra[g] + rb[g];
        e.z = (e.r == '0);
        q.push_back(e);
        glog.push_back(g);
        m_busy = 1;
        m_age  = 0;
      end else begin
        chk("idle_no_grant", 64'(req_ready), 64'd0);
      end
    end else begin
      m_age++;
      h = q[0];
      chk("op_req_ready", 64'(req_ready), 64'd0);
      chk("op_busy", 64'(busy), 64'd1);
      chk("op_alu_a", alu_a, h.a);
      chk("op_alu_b", alu_b, h.b);
      chk("op_alu_ctrl", 64'(alu_ctrl), 64'(h.c));
      if (m_age == 1) begin
        chk("exec_resp_valid", 64'(resp_valid), 64'd0);
      end else begin
        chk("resp_valid", 64'(resp_valid), 64'd1 << h.g);
        chk("resp_result", resp_result, h.r);
        chk("resp_zero", 64'(resp_zero), 64'(h.z));
        if (resp_ready[h.g]) begin
          void'(q.pop_front());
          m_busy = 0;
          m_ptr  = (h.g + 1) % NREQ;
        end
      end
    end
  end

  bit rand_mode      = 0;
  bit drop_on_accept = 1;

  task automatic cycle();
    logic [NREQ-1:0] acc;
    @(negedge clk);
    acc = req_valid & req_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (acc[i] && drop_on_accept) req_valid[i] = 1'b0;
      if (rand_mode) begin
        if (req_valid[i]) begin
          if ($urandom_range(0, 15) == 0) req_valid[i] = 1'b0;
        end else if ($urandom_range(0, 2) == 0) begin
          req_valid[i] = 1'b1;
          ra[i] = {$urandom, $urandom};
          rb[i] = ($urandom_range(0, 7) == 0) ? -ra[i] : {$urandom, $urandom};
          rc[i] = 3'($urandom);
        end
      end
    end
    if (rand_mode) resp_ready = 4'($urandom);
  endtask

  task automatic wait_idle();
    bit done = 0;
    for (int n = 0; n < 80 && !done; n++) begin
      cycle();
      if (!m_busy && req_valid == '0) done = 1;
    end
    chk("wait_idle_timeout", 64'(done), 64'd1);
  endtask

  task automatic do_reset();
    req_valid = '0;
    rst_n     = 1'b0;
    repeat (2) cycle();
    rst_n = 1'b1;
  endtask

  int rr_exp [5] = '{0, 1, 2, 3, 0};
  int base;

  initial begin
    rst_n      = 1'b0;
    req_valid  = '0;
    resp_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      ra[i] = '0;
      rb[i] = '0;
      rc[i] = '0;
    end
    repeat (3) cycle();
    rst_n = 1'b1;
    cycle();

    // single request
    ra[0] = 64'd5; rb[0] = 64'd7; rc[0] = 3'b010;
    resp_ready   = 4'hF;
    req_valid[0] = 1'b1;
    wait_idle();
    chk("single_result", resp_result, 64'd12);
    chk("single_zero", 64'(resp_zero), 64'd0);
    chk("single_grant", 64'(glog[glog.size()-1]), 64'd0);

    // round robin with all requesters valid continuously
    do_reset();
    for (int i = 0; i < NREQ; i++) begin
      ra[i] = 64'(i); rb[i] = '0; rc[i] = '0;
    end
    base = glog.size();
    drop_on_accept = 0;
    req_valid = 4'hF;
    for (int n = 0; n < 40 && glog.size() < base + 5; n++) cycle();
    req_valid = '0;
    drop_on_accept = 1;
    wait_idle();
    chk("rr_count", 64'(glog.size() - base), 64'd5);
    for (int i = 0; i < 5; i++) begin
      if (base + i < glog.size()) chk("rr_order", 64'(glog[base+i]), 64'(rr_exp[i]));
    end

    // backpressure on requester 2 while requester 1 waits
    ra[2] = 64'd100; rb[2] = 64'd23; rc[2] = 3'd1;
    resp_ready   = '0;
    req_valid[2] = 1'b1;
    repeat (3) cycle();
    ra[1] = 64'd40; rb[1] = 64'd2; rc[1] = 3'd6;
    req_valid[1] = 1'b1;
    repeat (10) cycle();
    chk("bp_resp_valid", 64'(resp_valid), 64'h4);
    chk("bp_req_ready", 64'(req_ready), 64'd0);
    chk("bp_result", resp_result, 64'd123);
    resp_ready = 4'hF;
    wait_idle();
    chk("bp_next_grant", 64'(glog[glog.size()-1]), 64'd1);

    // reset during EXEC
    ra[3] = 64'd1; rb[3] = 64'd1; rc[3] = 3'd3;
    req_valid[3] = 1'b1;
    cycle();
    chk("rstmid_grant", 64'(glog[glog.size()-1]), 64'd3);
    rst_n = 1'b0;
    #1;
    chk("rstmid_resp_valid", 64'(resp_valid), 64'd0);
    chk("rstmid_busy", 64'(busy), 64'd0);
    chk("rstmid_result", resp_result, 64'd0);
    chk("rstmid_alu_a", alu_a, 64'd0);
    req_valid = '0;
    repeat (2) cycle();
    rst_n = 1'b1;
    repeat (5) cycle();
    ra[1] = 64'd9; rb[1] = 64'd9;
    req_valid[1] = 1'b1;
    req_valid[3] = 1'b1;
    wait_idle();
    chk("rstmid_first", 64'(glog[glog.size()-2]), 64'd1);
    chk("rstmid_second", 64'(glog[glog.size()-1]), 64'd3);

    // wide operands wrapping to zero
    ra[0] = 64'hFFFF_FFFF_FFFF_FFFF; rb[0] = 64'd1; rc[0] = 3'd5;
    req_valid[0] = 1'b1;
    wait_idle();
    chk("wide_result", resp_result, 64'd0);
    chk("wide_zero", 64'(resp_zero), 64'd1);

    // randomized traffic with random response backpressure
    rand_mode = 1;
    repeat (400) cycle();
    rand_mode  = 0;
    req_valid  = '0;
    resp_ready = 4'hF;
    wait_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
